// File: rtl/q_sys_led_pwm_pkg.sv
// q_sys_led_pwm_pkg
//   Shared definitions for the LED brightness/blink stage: register map,
//   CTRL bit layout, default widths and reset values.
package q_sys_led_pwm_pkg;

  // Default geometry
  localparam int unsigned NUM_LEDS_DEF    = 4;
  localparam int unsigned PWM_BITS_DEF    = 8;
  localparam int unsigned BLINK_BITS_DEF  = 20;
  localparam int unsigned BLINK_RESET_DEF = 97656;  // ~0.5 s at 50 MHz with 256-clk PWM
  localparam logic [7:0]  DUTY_RESET_DEF  = 8'hFF;  // full on

  // Avalon bus widths
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  // Register map
  typedef enum logic [ADDR_W-1:0] {
    REG_CTRL   = 2'd0,
    REG_DUTY   = 2'd1,
    REG_BLINK  = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_BLINK_BIT  = 1;
  localparam int unsigned CTRL_INVERT_BIT = 2;

  // CTRL register image, MSB first so that bit 0 is enable
  typedef struct packed {
    logic invert;
    logic blink_en;
    logic enable;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{invert: 1'b0, blink_en: 1'b0, enable: 1'b1};

  // STATUS layout
  localparam int unsigned STATUS_PHASE_BIT = 0;
  localparam int unsigned STATUS_PWM_LSB   = 8;

endpackage

// File: rtl/q_sys_led_pwm_if.sv
// q_sys_led_pwm_if
//   Avalon-MM slave bundle for the LED PWM stage (zero read latency,
//   write on chipselect && ~write_n).
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, combinational from address
interface q_sys_led_pwm_if;
  import q_sys_led_pwm_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/q_sys_led_pwm_chan.sv
// q_sys_led_pwm_chan
//   One LED channel: compares the shared PWM counter against this channel's
//   duty, applies the blink gate, enable bypass and polarity, and registers
//   the pin drive.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_led         : LED level from the PIO
//   i_duty        : channel duty (all ones = 100 %)
//   i_pwm_cnt     : shared free-running PWM counter
//   i_blink_gate  : 1 when the blink stage lets the LED through
//   i_enable      : 0 bypasses PWM and blink
//   i_invert      : flips the output polarity
//   o_led         : registered pin drive
module q_sys_led_pwm_chan #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_led,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_blink_gate,
  input  logic                i_enable,
  input  logic                i_invert,
  output logic                o_led
);

  logic w_pwm_on;
  logic w_gate;
  logic r_led;

  // All-ones duty is a true 100 %, not (2**PWM_BITS-1)/2**PWM_BITS.
  assign w_pwm_on = (i_duty == {PWM_BITS{1'b1}}) | (i_pwm_cnt < i_duty);
  assign w_gate   = i_enable ? (i_led & w_pwm_on & i_blink_gate) : i_led;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= w_gate ^ i_invert;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/q_sys_led_pwm.sv
// q_sys_led_pwm
//   Brightness/blink stage between the LED PIO and the board LED pins.
//   Holds the slave registers, the free-running PWM counter, the blink
//   half-period timer and the read mux; per-LED gating lives in
//   q_sys_led_pwm_chan.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   s_avs    : Avalon-MM slave (CTRL, DUTY, BLINK, STATUS)
//   led_in   : LED levels from the PIO out_port
//   led_out  : registered LED pin drive
module q_sys_led_pwm
  import q_sys_led_pwm_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = NUM_LEDS_DEF,
  parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
  parameter int unsigned BLINK_BITS  = BLINK_BITS_DEF,
  parameter int unsigned BLINK_RESET = BLINK_RESET_DEF,
  parameter logic [PWM_BITS-1:0] DUTY_RESET = DUTY_RESET_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  q_sys_led_pwm_if.slave      s_avs,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int unsigned DUTY_W = NUM_LEDS * PWM_BITS;

  // Registers
  ctrl_t                 r_ctrl;
  logic [DUTY_W-1:0]     r_duty;
  logic [BLINK_BITS-1:0] r_blink;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [BLINK_BITS-1:0] r_blink_cnt;
  logic                  r_blink_phase;

  // Bus decode
  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_duty_wr;
  logic                  w_blink_wr;
  logic                  w_blink_stop;

  // Timers
  logic                  w_pwm_wrap;
  logic [BLINK_BITS-1:0] w_blink_half;
  logic                  w_blink_last;
  logic                  w_blink_gate;
  logic [DATA_W-1:0]     w_readdata;

  assign w_wr       = s_avs.chipselect & ~s_avs.write_n;
  assign w_ctrl_wr  = w_wr & (s_avs.address == REG_CTRL);
  assign w_duty_wr  = w_wr & (s_avs.address == REG_DUTY);
  assign w_blink_wr = w_wr & (s_avs.address == REG_BLINK);
  // Any CTRL write that leaves blink_en clear parks the blink timer with the
  // LEDs visible, so re-enabling blink always starts a fresh half-period.
  assign w_blink_stop = w_ctrl_wr & ~s_avs.writedata[CTRL_BLINK_BIT];

  assign w_pwm_wrap   = &r_pwm_cnt;
  // A half-period of 0 behaves as 1 so the terminal count never underflows.
  assign w_blink_half = (r_blink == '0) ? BLINK_BITS'(1) : r_blink;
  assign w_blink_last = (r_blink_cnt == w_blink_half - BLINK_BITS'(1));
  assign w_blink_gate = r_blink_phase | ~r_ctrl.blink_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl        <= CTRL_RESET;
      r_duty        <= {NUM_LEDS{DUTY_RESET}};
      r_blink       <= BLINK_BITS'(BLINK_RESET);
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);

      if (w_ctrl_wr) begin
        r_ctrl <= ctrl_t'(s_avs.writedata[2:0]);
      end
      if (w_duty_wr) begin
        r_duty <= s_avs.writedata[DUTY_W-1:0];
      end
      if (w_blink_wr) begin
        r_blink <= s_avs.writedata[BLINK_BITS-1:0];
      end

      // Register writes take priority over a coincident PWM wrap.
      if (w_blink_stop) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b1;
      end else if (w_blink_wr) begin
        r_blink_cnt <= '0;
      end else if (w_pwm_wrap) begin
        if (w_blink_last) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BLINK_BITS'(1);
        end
      end
    end
  end

  // Zero-latency read mux; unimplemented bits read 0.
  always_comb begin
    w_readdata = '0;
    case (s_avs.address)
      REG_CTRL:   w_readdata[2:0]            = r_ctrl;
      REG_DUTY:   w_readdata[DUTY_W-1:0]     = r_duty;
      REG_BLINK:  w_readdata[BLINK_BITS-1:0] = r_blink;
      REG_STATUS: begin
        w_readdata[STATUS_PHASE_BIT]            = r_blink_phase;
        w_readdata[STATUS_PWM_LSB +: PWM_BITS]  = r_pwm_cnt;
      end
      default:    w_readdata = '0;
    endcase
  end

  assign s_avs.readdata = w_readdata;

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      q_sys_led_pwm_chan #(
        .PWM_BITS (PWM_BITS)
      ) u_chan (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_led        (led_in[gi]),
        .i_duty       (r_duty[gi*PWM_BITS +: PWM_BITS]),
        .i_pwm_cnt    (r_pwm_cnt),
        .i_blink_gate (w_blink_gate),
        .i_enable     (r_ctrl.enable),
        .i_invert     (r_ctrl.invert),
        .o_led        (led_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_q_sys_led_pwm.sv
// tb_q_sys_led_pwm
//   Directed + randomized bench for q_sys_led_pwm. The reference model works
//   from elapsed clock edges: pwm_cnt is edges mod 256, and the blink phase is
//   derived from the number of PWM wraps since the last timer restart divided
//   by the half-period.
module tb_q_sys_led_pwm;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] led_in  = 4'hF;
  logic [3:0] led_out;

  q_sys_led_pwm_if bus ();

  q_sys_led_pwm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_avs   (bus),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  int          rel_edge = 0;   // edge_cnt when reset was released
  int          rst_r    = 0;   // state index of last blink timer restart
  bit          phase0   = 1'b1;
  logic [2:0]  m_ctrl   = 3'b001;
  logic [31:0] m_duty   = 32'hFFFF_FFFF;
  int          m_blink  = 97656;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit phase_at(input int j);
    int half;
    int wraps;
    half  = (m_blink == 0) ? 1 : m_blink;
    wraps = j / 256 - rst_r / 256;
    return phase0 ^ bit'((wraps / half) % 2);
  endfunction

  function automatic logic [3:0] exp_led(input int j);
    logic [3:0] g;
    int p;
    bit ph;
    p  = j % 256;
    ph = phase_at(j);
    for (int i = 0; i < 4; i++) begin
      int d;
      bit on;
      bit gv;
      d  = int'(m_duty[8*i +: 8]);
      on = (d == 255) || (p < d);
      gv = m_ctrl[0] ? (led_in[i] && on && (ph || !m_ctrl[1])) : led_in[i];
      g[i] = gv ^ m_ctrl[2];
    end
    return g;
  endfunction

  function automatic logic [31:0] exp_status();
    int j;
    logic [7:0] p;
    j = edge_cnt - rel_edge;
    p = 8'(j % 256);
    return {16'h0, p, 7'h0, phase_at(j)};
  endfunction

  task automatic model_release();
    rel_edge = edge_cnt;
    rst_r    = 0;
    phase0   = 1'b1;
    m_ctrl   = 3'b001;
    m_duty   = 32'hFFFF_FFFF;
    m_blink  = 97656;
  endtask

  // Called just after a negedge; samples before the next posedge.
  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    data = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Called just after a negedge; the write lands on the next posedge and the
  // task returns at the following negedge with the model updated.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    int wj;
    wj = edge_cnt + 1 - rel_edge;
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    case (addr)
      2'd0: begin
        if (!data[1]) begin
          rst_r  = wj;
          phase0 = 1'b1;
        end
        m_ctrl = data[2:0];
      end
      2'd1: m_duty = data;
      2'd2: begin
        phase0  = phase_at(wj - 1);
        rst_r   = wj;
        m_blink = int'(data[19:0]);
      end
      default: ;
    endcase
  endtask

  task automatic run_check(input int n, input bit rand_in);
    repeat (n) begin
      @(negedge clk);
      chk("led_out", {28'h0, led_out}, {28'h0, exp_led(edge_cnt - rel_edge - 1)});
      if (rand_in) led_in = 4'($urandom);
    end
  endtask

  // Polls STATUS until blink_phase differs from its current value.
  task automatic wait_phase_change(input int limit, output int at_state, output bit ok);
    logic [31:0] rd;
    bit start;
    ok = 1'b0;
    at_state = 0;
    bus_read(2'd3, rd);
    start = rd[0];
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      bus_read(2'd3, rd);
      if (rd[0] != start) begin
        at_state = edge_cnt - rel_edge;
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int hi [4];
    int t0, t1;
    bit ok;
    bit p_before;
    logic [2:0] rctrl;

    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;

    // 1 Reset state and release
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_led_out", {28'h0, led_out}, 32'h0);
    bus_read(2'd0, rd); chk("reset_ctrl",  rd, 32'h1);
    bus_read(2'd1, rd); chk("reset_duty",  rd, 32'hFFFF_FFFF);
    bus_read(2'd2, rd); chk("reset_blink", rd, 32'd97656);
    @(negedge clk);
    led_in  = 4'hF;
    reset_n = 1'b1;
    model_release();
    bus_read(2'd3, rd); chk("release_status", rd, 32'h1);
    @(negedge clk);
    chk("release_led_1clk", {28'h0, led_out}, 32'hF);
    run_check(20, 1'b0);

    // 2 Per-channel duty over one full PWM period
    @(negedge clk);
    bus_write(2'd1, 32'h0000_40FF);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (256) begin
      @(negedge clk);
      chk("duty_led_out", {28'h0, led_out}, {28'h0, exp_led(edge_cnt - rel_edge - 1)});
      for (int i = 0; i < 4; i++) hi[i] += int'(led_out[i]);
    end
    chk("duty_hi_led0", hi[0], 256);
    chk("duty_hi_led1", hi[1], 64);
    chk("duty_hi_led2", hi[2], 0);
    chk("duty_hi_led3", hi[3], 0);

    // 3 Blink with half-period 2 PWM periods
    @(negedge clk);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3);
    run_check(1100, 1'b0);
    @(negedge clk);
    wait_phase_change(1200, t0, ok);
    chk("blink2_edge_a", {31'h0, ok}, 32'h1);
    @(negedge clk);
    wait_phase_change(1200, t1, ok);
    chk("blink2_edge_b", {31'h0, ok}, 32'h1);
    chk("blink2_period", t1 - t0, 512);
    ok = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      bus_read(2'd3, rd);
      if (rd[0] == 1'b0) begin ok = 1'b1; break; end
    end
    chk("blink2_phase0_seen", {31'h0, ok}, 32'h1);
    @(negedge clk);
    chk("blink2_dark", {28'h0, led_out}, 32'h0);
    bus_write(2'd0, 32'h1);
    bus_read(2'd3, rd);
    chk("blink_off_phase", {31'h0, rd[0]}, 32'h1);
    chk("blink_off_status", rd, exp_status());
    @(negedge clk);
    chk("blink_off_led0", {31'h0, led_out[0]}, 32'h1);

    // 4 BLINK=0 acts as 1; write on the wrap edge suppresses the toggle
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h3);
    @(negedge clk);
    wait_phase_change(600, t0, ok);
    chk("blink0_edge_a", {31'h0, ok}, 32'h1);
    @(negedge clk);
    wait_phase_change(600, t1, ok);
    chk("blink0_edge_b", {31'h0, ok}, 32'h1);
    chk("blink0_period", t1 - t0, 256);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((edge_cnt - rel_edge) % 256 == 255) begin ok = 1'b1; break; end
    end
    chk("wrap_align", {31'h0, ok}, 32'h1);
    bus_read(2'd3, rd);
    p_before = rd[0];
    bus_write(2'd2, 32'd0);
    bus_read(2'd3, rd);
    chk("wrap_write_status", rd, {16'h0, 8'h00, 7'h0, p_before});
    run_check(600, 1'b1);

    // 5 Enable off, invert on: pass-through inverted
    @(negedge clk);
    bus_write(2'd0, 32'h4);
    led_in = 4'b1010;
    @(negedge clk);
    chk("bypass_invert", {28'h0, led_out}, 32'h5);
    run_check(300, 1'b1);

    // Randomized configurations
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      bus_write(2'd1, $urandom);
      bus_write(2'd2, 32'($urandom_range(0, 2)));
      rctrl = 3'($urandom_range(0, 7));
      bus_write(2'd0, {29'h0, rctrl});
      bus_read(2'd0, rd);
      chk("rand_ctrl_rd", rd, {29'h0, rctrl});
      run_check(400, 1'b1);
      bus_read(2'd3, rd);
      chk("rand_status", rd, exp_status());
    end

    // 6 Reset mid-blink with DUTY=0
    @(negedge clk);
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h3);
    run_check(300, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midreset_led_out", {28'h0, led_out}, 32'h0);
    bus_read(2'd1, rd); chk("midreset_duty", rd, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("midreset_hold", {28'h0, led_out}, 32'h0);
    led_in  = 4'hF;
    reset_n = 1'b1;
    model_release();
    bus_read(2'd3, rd); chk("midreset_status", rd, 32'h1);
    bus_read(2'd0, rd); chk("midreset_ctrl", rd, 32'h1);
    bus_read(2'd2, rd); chk("midreset_blink", rd, 32'd97656);
    @(negedge clk);
    chk("midreset_follow", {28'h0, led_out}, 32'hF);
    run_check(50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
